// File: rtl/lc3_pipe_stage.sv
// Two-entry skid pipeline stage with flush, for the LC-3 datapath.
// Optional stall counter is built only when LC3_PIPE_STALL_CNT_EN is defined.
module lc3_pipe_stage #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cnt
);

  // Handshake: a word moves on a rising edge when valid and ready are both 1
  // on that side; valid never waits for ready, and a held word stays put.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_ready_q, out_valid_q;
  logic [1:0]       occ_q;
  logic             accept, emit;
  logic             load_main, load_skid, main_from_skid;

  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs are registered copies of the next state, so nothing reaches a
  // port combinationally from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= state_d;
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

`ifdef LC3_PIPE_STALL_CNT_EN
  logic [15:0] stall_q;

  // Survives flush on purpose: it measures back-pressure across squashes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3_pipe_stage.sv
// Scoreboarded bench for lc3_pipe_stage: the reference is a bounded queue of
// accepted words; directed scenarios are followed by random traffic.
module tb_lc3_pipe_stage;
  localparam int          W    = 16;
  localparam logic [15:0] RVAL = 16'h3000;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  lc3_pipe_stage #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_head;
  logic [15:0]  exp_stall;
  bit           model_live = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           emitted = 0;
  bit           beef_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit acc_m, emit_m;
    if (model_live) begin
      chk("occupancy", occupancy, exp_q.size());
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      else                   chk("out_data_hold", out_data, last_head);
      chk("stall_cnt", stall_cnt, exp_stall);
    end
    acc_m  = in_valid && (exp_q.size() < 2);
    emit_m = (exp_q.size() != 0) && out_ready;
    if (rst) begin
      exp_q.delete();
      last_head  = RVAL;
      exp_stall  = 16'h0000;
      model_live = 1;
    end else if (model_live) begin
`ifdef LC3_PIPE_STALL_CNT_EN
      if (exp_q.size() != 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
`endif
      if (emit_m) begin
        if (exp_q[0] == 16'hBEEF) beef_seen = 1;
        emitted++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (emit_m) void'(exp_q.pop_front());
        if (acc_m) exp_q.push_back(in_data);
        if (exp_q.size() != 0) last_head = exp_q[0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
  endtask

  initial begin
    int emitted_before;
    rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    @(posedge clk); #1;
    do_reset();
    step(0, 0, 0, '0, 1);

    // single word, latency 1
    step(0, 0, 1, 16'h3000, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // fill to two, third offer held off, then drain in order
    step(0, 0, 1, 16'hA001, 0);
    step(0, 0, 1, 16'hA002, 0);
    step(0, 0, 1, 16'hA003, 0);
    step(0, 0, 1, 16'hA003, 0);
    step(0, 0, 1, 16'hA003, 1);
    step(0, 0, 1, 16'hA003, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);

    // full-rate streaming
    emitted_before = emitted;
    for (int i = 0; i < 100; i++) step(0, 0, 1, W'(i), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    chk("stream_count", emitted - emitted_before, 100);

    // flush from full, BEEF must be discarded
    step(0, 0, 1, 16'h1111, 0);
    step(0, 0, 1, 16'h2222, 0);
    step(0, 1, 1, 16'hBEEF, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    chk("beef_never_emitted", beef_seen, 0);

    // reset and flush together while full
    step(0, 0, 1, 16'h4444, 0);
    step(0, 0, 1, 16'h5555, 0);
    step(1, 1, 1, 16'h6666, 1);
    step(0, 0, 0, '0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           $urandom_range(0, 1), W'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    chk("beef_random_guard", beef_seen, 0);

`ifdef LC3_PIPE_STALL_CNT_EN
    // saturate the stall counter, then flush keeps it and reset clears it
    do_reset();
    step(0, 0, 1, 16'h7777, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, '0, 0);
    chk("stall_saturated", stall_cnt, 16'hFFFF);
    step(0, 1, 0, '0, 0);
    chk("stall_after_flush", stall_cnt, 16'hFFFF);
    do_reset();
    chk("stall_after_rst", stall_cnt, 16'h0000);
`else
    step(0, 0, 1, 16'h7777, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, '0, 0);
    chk("stall_tied_zero", stall_cnt, 16'h0000);
`endif

    step(0, 0, 0, '0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
